// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   state_e : arbiter FSM states
//   owner_e : which pipeline port owns the current RAM transaction
//   CNT_W   : width of the read-latency down-counter (RD_LAT up to 7)
package mem_arb_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch port, data port, RAM port and busy flag.
//   slave  : arbiter view (takes requests, drives ready/rdata and the RAM)
//   master : environment view (pipeline requesters and the RAM itself)
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  // Instruction-fetch port (read-only)
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  // Data (MEM-stage) port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  // Single-port synchronous RAM
  logic          ram_ena;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          busy;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output ram_ena, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  ram_ena, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req[1:0] : pending requests, indexed by owner_e (0 = inst, 1 = data)
//   last     : owner granted most recently
//   gnt      : chosen owner (only meaningful when valid)
//   valid    : at least one request pending
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output owner_e     gnt,
  output logic       valid
);

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt   = OWN_INST;
    valid = |req;
    case (req)
      2'b01:   gnt = OWN_INST;
      2'b10:   gnt = OWN_DATA;
      2'b11:   gnt = (last == OWN_INST) ? OWN_DATA : OWN_INST;
      default: gnt = OWN_INST;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the fetch and
// data ports of the pipeline, one transaction at a time, round-robin on ties.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fetch port (i_*), data port (d_*), RAM port (ram_*), busy
//   RD_LAT   : RAM read latency in cycles, legal range 1..7
// Every output is a register; ready pulses last exactly one cycle (RESP).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  owner_e           r_last,      w_last_nxt;
  owner_e           r_owner,     w_owner_nxt;
  logic             r_ram_ena,   w_ram_ena_nxt;
  logic             r_ram_we,    w_ram_we_nxt;
  logic [AW-1:0]    r_ram_addr,  w_ram_addr_nxt;
  logic [DW-1:0]    r_ram_wdata, w_ram_wdata_nxt;
  logic [DW-1:0]    r_i_rdata,   w_i_rdata_nxt;
  logic [DW-1:0]    r_d_rdata,   w_d_rdata_nxt;
  logic             r_i_ready,   w_i_ready_nxt;
  logic             r_d_ready,   w_d_ready_nxt;
  logic             r_busy;

  owner_e           w_gnt;
  logic             w_gnt_vld;

  // Round-robin choice between the two request lines
  rr_arb2 u_rr (
    .req   ({bus.d_req, bus.i_req}),
    .last  (r_last),
    .gnt   (w_gnt),
    .valid (w_gnt_vld)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_owner_nxt     = r_owner;
    w_ram_ena_nxt   = 1'b0;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_i_rdata_nxt   = r_i_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_i_ready_nxt   = 1'b0;
    w_d_ready_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Latch the winner straight into the RAM registers so ISSUE drives them.
        if (w_gnt_vld) begin
          w_owner_nxt   = w_gnt;
          w_ram_ena_nxt = 1'b1;
          if (w_gnt == OWN_DATA) begin
            w_ram_we_nxt    = bus.d_we;
            w_ram_addr_nxt  = bus.d_addr;
            w_ram_wdata_nxt = bus.d_wdata;
          end else begin
            w_ram_we_nxt    = 1'b0;
            w_ram_addr_nxt  = bus.i_addr;
            w_ram_wdata_nxt = '0;
          end
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (r_ram_we) begin
          w_d_ready_nxt = (r_owner == OWN_DATA);
          w_i_ready_nxt = (r_owner == OWN_INST);
          w_state_nxt   = S_RESP;
        end else begin
          w_cnt_nxt   = LAT_LOAD;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        // cnt==1 marks the cycle in which ram_rdata is valid.
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          if (r_owner == OWN_DATA) begin
            w_d_rdata_nxt = bus.ram_rdata;
            w_d_ready_nxt = 1'b1;
          end else begin
            w_i_rdata_nxt = bus.ram_rdata;
            w_i_ready_nxt = 1'b1;
          end
          w_state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        // Requester still holds req here, so no grant is made this cycle.
        w_last_nxt  = r_owner;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last      <= OWN_INST;
      r_owner     <= OWN_INST;
      r_ram_ena   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_owner     <= w_owner_nxt;
      r_ram_ena   <= w_ram_ena_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_i_ready   <= w_i_ready_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.ram_ena   = r_ram_ena;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// dut_a (RD_LAT=1) is driven with directed transactions whose expected RAM
// issue and response are queued up front; monitors pop and compare on every
// ram_ena and ready pulse. dut_b (RD_LAT=3) covers the longer-latency timing.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int          RD_LAT_A = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // RAM models: data is only correct in the cycle RD_LAT after ram_ena.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 1) ? 32'h2002_0005 : (32'h1000_0000 | 32'(i));
    end else if (bus_a.ram_ena && bus_a.ram_we) begin
      mem[bus_a.ram_addr[9:2]] <= bus_a.ram_wdata;
    end
    pipe_a <= (bus_a.ram_ena && !bus_a.ram_we) ? mem[bus_a.ram_addr[9:2]] : 32'hDEAD_BEEF;
    pipe_b[0] <= (bus_b.ram_ena && !bus_b.ram_we) ? mem[bus_b.ram_addr[9:2]] : 32'hDEAD_BEEF;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.ram_rdata = pipe_a;
  assign bus_b.ram_rdata = pipe_b[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries; ena/rdy cycle of -1 means "not pinned".
  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ena_cyc;
    int          rdy_cyc;
  } txn_t;

  txn_t q_ena[$];
  txn_t q_rsp[$];

  function automatic txn_t mk(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ena, input int rdy);
    txn_t x;
    x.port = port; x.we = we; x.addr = addr; x.wdata = wdata; x.rdata = rdata;
    x.ena_cyc = ena; x.rdy_cyc = rdy;
    return x;
  endfunction

  task automatic expect_txn(input txn_t x);
    q_ena.push_back(x);
    q_rsp.push_back(x);
  endtask

  // Monitor for dut_a: RAM issue and ready pulses.
  txn_t mon_e, mon_r;
  int   last_ena_cyc = 0;

  always @(negedge clk) begin
    check("ram_we_without_ena", 64'(bus_a.ram_we & ~bus_a.ram_ena), 64'd0);
    if (bus_a.ram_ena) begin
      if (q_ena.size() == 0) begin
        check("unexpected_ram_ena", 64'(bus_a.ram_ena), 64'd0);
      end else begin
        mon_e = q_ena.pop_front();
        check("ena_addr", 64'(bus_a.ram_addr), 64'(mon_e.addr));
        check("ena_we", 64'(bus_a.ram_we), 64'(mon_e.we));
        if (mon_e.we) check("ena_wdata", 64'(bus_a.ram_wdata), 64'(mon_e.wdata));
        if (mon_e.ena_cyc >= 0) check("ena_cycle", 64'(cyc), 64'(mon_e.ena_cyc));
        last_ena_cyc = cyc;
      end
    end
    if (bus_a.i_ready || bus_a.d_ready) begin
      check("both_ready", 64'(bus_a.i_ready & bus_a.d_ready), 64'd0);
      if (q_rsp.size() == 0) begin
        check("unexpected_ready", 64'({bus_a.d_ready, bus_a.i_ready}), 64'd0);
      end else begin
        mon_r = q_rsp.pop_front();
        check("ready_port", 64'(bus_a.d_ready), 64'(mon_r.port));
        if (!mon_r.we)
          check("rdata", 64'(mon_r.port ? bus_a.d_rdata : bus_a.i_rdata), 64'(mon_r.rdata));
        check("ena_to_ready", 64'(cyc - last_ena_cyc), 64'(mon_r.we ? 1 : 1 + RD_LAT_A));
        if (mon_r.rdy_cyc >= 0) check("ready_cycle", 64'(cyc), 64'(mon_r.rdy_cyc));
      end
    end
  end

  task automatic check_zero_a(input string tag);
    check({tag, "_ram_ena"},   64'(bus_a.ram_ena),   64'd0);
    check({tag, "_ram_we"},    64'(bus_a.ram_we),    64'd0);
    check({tag, "_ram_addr"},  64'(bus_a.ram_addr),  64'd0);
    check({tag, "_ram_wdata"}, 64'(bus_a.ram_wdata), 64'd0);
    check({tag, "_i_ready"},   64'(bus_a.i_ready),   64'd0);
    check({tag, "_d_ready"},   64'(bus_a.d_ready),   64'd0);
    check({tag, "_i_rdata"},   64'(bus_a.i_rdata),   64'd0);
    check({tag, "_d_rdata"},   64'(bus_a.d_rdata),   64'd0);
    check({tag, "_busy"},      64'(bus_a.busy),      64'd0);
  endtask

  // One fetch: hold request until i_ready, return in the following cycle.
  task automatic drive_i(input logic [31:0] addr);
    int n;
    bus_a.i_req  = 1'b1;
    bus_a.i_addr = addr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.i_ready && n < 40);
    if (!bus_a.i_ready) check("i_ready_timeout", 64'(bus_a.i_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    bus_a.d_req   = 1'b1;
    bus_a.d_we    = we;
    bus_a.d_addr  = addr;
    bus_a.d_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.d_ready && n < 40);
    if (!bus_a.d_ready) check("d_ready_timeout", 64'(bus_a.d_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus_a.i_req = 1'b0; bus_a.i_addr = '0;
    bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.i_req = 1'b0; bus_b.i_addr = '0;
    bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_a("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Isolated fetch: ram_ena at t+1, ready at t+3
    t = cyc;
    expect_txn(mk(OWN_INST, 1'b0, 32'h4, 32'h0, 32'h2002_0005, t + 1, t + 3));
    drive_i(32'h4);
    bus_a.i_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Store then back-to-back load from the same port
    t = cyc;
    expect_txn(mk(OWN_DATA, 1'b1, 32'h50, 32'h7, 32'h0, t + 1, t + 2));
    drive_d(1'b1, 32'h50, 32'h7);
    t = cyc;
    expect_txn(mk(OWN_DATA, 1'b0, 32'h50, 32'h0, 32'h7, t + 1, t + 3));
    drive_d(1'b0, 32'h50, 32'h0);
    bus_a.d_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Tie after reset goes to data, then strict alternation
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t = cyc;
    expect_txn(mk(OWN_DATA, 1'b0, 32'h8,  32'h0, 32'h1000_0002, t + 1,  t + 3));
    expect_txn(mk(OWN_INST, 1'b0, 32'h4,  32'h0, 32'h2002_0005, t + 5,  t + 7));
    expect_txn(mk(OWN_DATA, 1'b0, 32'h50, 32'h0, 32'h7,         t + 9,  t + 11));
    expect_txn(mk(OWN_INST, 1'b0, 32'hC,  32'h0, 32'h1000_0003, t + 13, t + 15));
    fork
      begin
        drive_d(1'b0, 32'h8, 32'h0);
        drive_d(1'b0, 32'h50, 32'h0);
        bus_a.d_req = 1'b0;
      end
      begin
        drive_i(32'h4);
        drive_i(32'hC);
        bus_a.i_req = 1'b0;
      end
    join

    // Reset while in WAIT: no ready, outputs cleared, next fetch normal
    t = cyc;
    q_ena.push_back(mk(OWN_INST, 1'b0, 32'h8, 32'h0, 32'h0, t + 1, -1));
    bus_a.i_req  = 1'b1;
    bus_a.i_addr = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_busy", 64'(bus_a.busy), 64'd1);
    rst = 1'b1;
    bus_a.i_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero_a("rst_in_wait");
    @(posedge clk); #1;
    t = cyc;
    expect_txn(mk(OWN_INST, 1'b0, 32'h4, 32'h0, 32'h2002_0005, t + 1, t + 3));
    drive_i(32'h4);
    bus_a.i_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // RD_LAT=3: ram_ena at t+1, ready at t+5, busy t+1..t+5
    t = cyc;
    bus_b.i_req  = 1'b1;
    bus_b.i_addr = 32'h4;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check("lat3_busy",    64'(bus_b.busy),    64'((k >= 1 && k <= 5) ? 1 : 0));
      check("lat3_ram_ena", 64'(bus_b.ram_ena), 64'((k == 1) ? 1 : 0));
      check("lat3_i_ready", 64'(bus_b.i_ready), 64'((k == 5) ? 1 : 0));
      if (k == 5) begin
        check("lat3_i_rdata", 64'(bus_b.i_rdata), 64'h2002_0005);
        bus_b.i_req = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    check("pending_ena", 64'(q_ena.size()), 64'd0);
    check("pending_rsp", 64'(q_rsp.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous RAM between the pipeline's instruction-fetch port and its data (MEM-stage) port, for a unified-memory build of the MIPS core. Grants one transaction at a time under 2-way round-robin. Sequences issue, read-latency wait and response through a small FSM. Returns per-port ready pulses from which the pipeline derives its IF and MEM stall signals.

## Interface
Parameters:
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- RD_LAT, 1, RAM read latency in cycles from `ram_ena` to valid `ram_rdata`; legal range 1..7

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request; held with `i_addr` until `i_ready`
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetched word; registered, valid while `i_ready`=1
- i_ready  out  1  one-cycle completion pulse for the fetch port
- d_req  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` until `d_ready`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; registered, valid while `d_ready`=1
- d_ready  out  1  one-cycle completion pulse for the data port
- ram_ena  out  1  RAM enable, asserted for exactly one cycle per transaction
- ram_we  out  1  RAM write enable; only asserted together with `ram_ena`
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If neither request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port that was not granted last.
  - `last_grant` resets to "inst", so the first tie goes to data.
  - On a grant: latch owner, address, write data and write enable into the RAM output registers, then go to ISSUE.
- **ISSUE**
  - `ram_ena`=1, with `ram_we` = the latched write enable.
  - A write goes straight to RESP.
  - A read loads `cnt` = RD_LAT and goes to WAIT.
- **WAIT**
  - Decrement `cnt` each cycle.
  - In the cycle where `cnt`==1, capture `ram_rdata` into the owner's rdata register (cycle ISSUE+RD_LAT), then go to RESP.
- **RESP**
  - Pulse the owner's ready output; the other port's ready stays 0.
  - Update `last_grant` to the owner.
  - Requests are ignored in this cycle. The requester still holds `req` because it only sees `ready` now.
  - Go to IDLE.
- Requesters deassert or change their request in the cycle after `ready`. A request present in IDLE is always treated as new.
- `i_rdata` and `d_rdata` hold their value until the next capture for that port. Writes do not modify `d_rdata`.
- The pipeline derives its stalls as `stall_if = i_req & ~i_ready` and `stall_mem = d_req & ~d_ready`; this logic sits outside the block.
- The instruction port is read-only; it has no write path.

## Timing
- **Reset:** state=IDLE, `cnt`=0, `last_grant`=inst. All outputs are 0: `ram_ena`, `ram_we`, `ram_addr`, `ram_wdata`, `i_ready`, `d_ready`, `i_rdata`, `d_rdata`, `busy`.
- **Reset mid-transaction:** the transaction is abandoned and no ready pulse is produced. `ram_ena` is low from the cycle after reset is sampled.
- **Read latency:** request sampled at cycle t → `ram_ena` at t+1 → ready at t+2+RD_LAT. With RD_LAT=1, ready arrives at t+3.
- **Write latency:** request sampled at t → `ram_ena`/`ram_we` at t+1 → ready at t+2.
- **Issue spacing:** the minimum distance between two `ram_ena` pulses is RD_LAT+3 cycles for reads and 3 cycles for writes.
- **Starvation bound:** with both ports continuously requesting, grants strictly alternate, so neither port waits more than one foreign transaction.
- **Simultaneous events:** a request arriving during ISSUE, WAIT or RESP waits for IDLE. A new request from the port being serviced in RESP is not granted in that RESP cycle.
- **Counter:** `cnt` is 3 bits and never wraps, because it is loaded only in ISSUE and only with a value ≥ 1.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (`S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_RESP`)
  - the owner encoding (`OWN_INST`=0, `OWN_DATA`=1)
  - the `cnt` width constant
- Sub-module `rr_arb2`: purely combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt`, `valid`.
- Everything else (FSM, counter, output registers) lives in `mem_arbiter`.

## Test plan
- **Read timing:** RD_LAT=1, `i_req` with `i_addr`=0x0000_0004 and RAM word 0x2002_0005 → `ram_ena` at t+1, `i_ready`=1 with `i_rdata`=0x2002_0005 at t+3 only.
- **Store then load:** `d_req`, `d_we`=1, `d_addr`=0x50, `d_wdata`=0x0000_0007 → `ram_we`=1 at t+1, `d_ready` at t+2. A follow-up load from 0x50 returns 0x0000_0007.
- **Tie-breaking after reset:** both requests are pending at the first IDLE after reset → data is granted first, fetch next. After that, continuous requests alternate I, D, I, D.
- **Longer latency:** RD_LAT=3 read → `ram_ena` at t+1, capture at t+4, ready at t+5. `busy` is high t+1..t+5.
- **Reset during WAIT:** assert `rst` during WAIT → no ready pulse. All outputs are 0 the following cycle, and the next request completes normally.
- **RESP cycle ignores requests:** requester holds `req` through RESP → no second `ram_ena` from that RESP cycle. A new grant occurs only from IDLE.
